// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings and defaults for the stall controller
package hazard_ctrl_pkg;
    localparam int REG_W = 5;
    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_LOAD
    } md_state_e;

    // A register read hazards if its writer's result arrives later than it is needed
    function automatic logic src_hazard(
        input logic [REG_W-1:0] src,
        input logic [1:0]       tuse,
        input logic [REG_W-1:0] e_a3,
        input logic [1:0]       e_tnew,
        input logic [REG_W-1:0] m_a3,
        input logic [1:0]       m_tnew
    );
        return (src != '0) &&
               ((src == e_a3 && tuse < e_tnew) || (src == m_a3 && tuse < m_tnew));
    endfunction
endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// md_busy_timer: countdown covering the multiply/divide unit busy window
module md_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic E_md_start,
    input  logic E_md_is_div,
    output logic md_busy
);
    logic [3:0] md_cnt;
    md_state_e  state;

    // A new start always reloads, even mid-count
    always_comb state = E_md_start ? MD_LOAD : (md_cnt != '0 ? MD_BUSY : MD_IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (state == MD_LOAD)
            md_cnt <= E_md_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        else if (state == MD_BUSY)
            md_cnt <= md_cnt - 4'd1;
    end

    assign md_busy = md_cnt != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tuse/Tnew data-hazard and MDU-busy stall control.
// Define STALL_CNT_EN to add the 32-bit stall_cnt counter port.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic [1:0]       D_Tuse_rs,
    input  logic [1:0]       D_Tuse_rt,
    input  logic             D_is_md,
    input  logic [REG_W-1:0] E_A3,
    input  logic [1:0]       E_Tnew,
    input  logic [REG_W-1:0] M_A3,
    input  logic [1:0]       M_Tnew,
    input  logic             E_md_start,
    input  logic             E_md_is_div,
    output logic             stall,
    output logic             PC_WrEn,
    output logic             D_WrEn,
    output logic             E_flush,
`ifdef STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic             md_busy
);
    logic rs_haz, rt_haz, md_haz;

    md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .md_busy     (md_busy)
    );

    always_comb begin
        rs_haz  = src_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
        rt_haz  = src_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
        md_haz  = D_is_md && (md_busy || E_md_start);
        stall   = !reset && (rs_haz || rt_haz || md_haz);
        PC_WrEn = !stall;
        D_WrEn  = !stall;
        E_flush = stall;
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors plus multi-cycle MDU sequences, scoreboard-checked
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clk = 0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_A3, M_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic       D_is_md, E_md_start, E_md_is_div;
    logic       stall, PC_WrEn, D_WrEn, E_flush, md_busy;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] model_cnt = 0;
`endif

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] tuse_rs, tuse_rt;
        logic       is_md;
        logic [4:0] e_a3;
        logic [1:0] e_tnew;
        logic [4:0] m_a3;
        logic [1:0] m_tnew;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[11];

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_is_md(D_is_md),
        .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .stall(stall), .PC_WrEn(PC_WrEn), .D_WrEn(D_WrEn), .E_flush(E_flush),
`ifdef STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Expected {stall, PC_WrEn, D_WrEn, E_flush, md_busy} queued at drive, checked mid-cycle
    task automatic cyc(input string name, input logic es, input logic eb);
        logic [4:0] exp, act;
        exp_q.push_back({es, !es, !es, es, eb});
`ifdef STALL_CNT_EN
        if (es && !reset) model_cnt = model_cnt + 1;
`endif
        @(negedge clk);
        exp = exp_q.pop_front();
        act = {stall, PC_WrEn, D_WrEn, E_flush, md_busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got stall/pc/d/flush/busy=%b expected %b", name, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_Tuse_rs = TUSE_NONE; D_Tuse_rt = TUSE_NONE;
        D_is_md = 0; E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0;
        E_md_start = 0; E_md_is_div = 0;
    endtask

    initial begin
        vecs[0]  = '{8, 0, 1, 3, 0, 8, 2, 0, 0, 1};
        vecs[1]  = '{8, 0, 1, 3, 0, 8, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 3, 0, 0, 2, 0, 0, 0};
        vecs[3]  = '{0, 9, 3, 0, 0, 0, 0, 9, 1, 1};
        vecs[4]  = '{0, 9, 3, 1, 0, 0, 0, 9, 1, 0};
        vecs[5]  = '{5, 0, 3, 3, 0, 5, 2, 0, 0, 0};
        vecs[6]  = '{5, 0, 0, 3, 0, 6, 2, 5, 1, 1};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[8]  = '{0, 0, 3, 3, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{7, 0, 0, 3, 0, 7, 0, 0, 0, 0};
        vecs[10] = '{0, 31, 3, 1, 0, 31, 2, 0, 0, 1};

        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        D_rs = 8; D_Tuse_rs = 1; E_A3 = 8; E_Tnew = 2; D_is_md = 1;
        cyc("reset_forces_no_stall", 0, 0);
        reset = 0;
        idle_inputs();

        for (int i = 0; i < 11; i++) begin
            D_rs = vecs[i].rs; D_rt = vecs[i].rt;
            D_Tuse_rs = vecs[i].tuse_rs; D_Tuse_rt = vecs[i].tuse_rt;
            D_is_md = vecs[i].is_md;
            E_A3 = vecs[i].e_a3; E_Tnew = vecs[i].e_tnew;
            M_A3 = vecs[i].m_a3; M_Tnew = vecs[i].m_tnew;
            cyc($sformatf("vec%0d", i), vecs[i].exp_stall, 0);
        end
        idle_inputs();

        // mult at T with mflo held in D
        D_is_md = 1; E_md_start = 1;
        cyc("mult_T", 1, 0);
        E_md_start = 0;
        for (int i = 1; i <= 5; i++) cyc($sformatf("mult_T+%0d", i), 1, 1);
        D_rs = 4; D_Tuse_rs = 0; E_A3 = 4; E_Tnew = 2;
        cyc("mult_T+6_data_only", 1, 0);
        idle_inputs();
        D_is_md = 1;
        cyc("mult_done", 0, 0);
        D_is_md = 0;

        // div interrupted by reset at T+3
        E_md_start = 1; E_md_is_div = 1;
        cyc("div_T", 0, 0);
        E_md_start = 0;
        cyc("div_T+1", 0, 1);
        cyc("div_T+2", 0, 1);
        reset = 1; D_is_md = 1;
        cyc("div_reset_T+3", 0, 1);
        cyc("div_reset_T+4", 0, 0);
        reset = 0; D_is_md = 0;

        // div restarted by a mult at T+2
        E_md_start = 1; E_md_is_div = 1;
        cyc("restart_T", 0, 0);
        E_md_start = 0;
        cyc("restart_T+1", 0, 1);
        E_md_start = 1; E_md_is_div = 0;
        cyc("restart_T+2", 0, 1);
        E_md_start = 0;
        for (int i = 3; i <= 7; i++) cyc($sformatf("restart_T+%0d", i), 0, 1);
        cyc("restart_T+8", 0, 0);

`ifdef STALL_CNT_EN
        @(negedge clk);
        checks++;
        if (stall_cnt !== model_cnt) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, model_cnt);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall controller for the five-stage core. It compares the D-stage instruction's register-use timing (Tuse) against the pending writes in E and M (Tnew), and tracks the multiply/divide unit's busy window with an internal countdown. From these it drives the hold/bubble controls: PC write enable, D pipeline register write enable, and E pipeline register flush.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles after a mult/multu start.
- DIV_CYCLES, default 10: busy cycles after a div/divu start.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- D_rs  in  5  rs field of the D-stage instruction.
- D_rt  in  5  rt field of the D-stage instruction.
- D_Tuse_rs  in  2  cycles until D needs rs (3 = not used).
- D_Tuse_rt  in  2  cycles until D needs rt (3 = not used).
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_A3  in  5  destination register of the E-stage instruction (0 = none).
- E_Tnew  in  2  cycles until the E result is ready (0..2).
- M_A3  in  5  destination register of the M-stage instruction.
- M_Tnew  in  2  cycles until the M result is ready (0..1).
- E_md_start  in  1  E instruction starts the MDU this cycle.
- E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
- stall  out  1  hold F/D and bubble E.
- PC_WrEn  out  1  equals ~stall.
- D_WrEn  out  1  equals ~stall.
- E_flush  out  1  equals stall.
- md_busy  out  1  MDU countdown is nonzero.
- stall_cnt  out  32  stall cycle count. Present only when the macro in Configuration is defined.

## Operation
- rs data hazard: D_rs != 0, and either (D_rs == E_A3 and D_Tuse_rs < E_Tnew) or (D_rs == M_A3 and D_Tuse_rs < M_Tnew). The rt hazard uses the same rule with D_rt and D_Tuse_rt.
- MD hazard: D_is_md and (md_busy or E_md_start).
- stall is the OR of the rs, rt and MD hazards, and is forced to 0 while reset is high.
- W-stage writes never cause a stall; they are covered by forwarding and the register-file bypass.
- Countdown md_cnt (4 bits) has 3 states: IDLE (cnt = 0), BUSY (cnt > 0), and LOAD (the start event).
  - E_md_start: cnt <= E_md_is_div ? DIV_CYCLES : MULT_CYCLES. Start has priority over decrement, so it restarts the count even when busy.
  - Otherwise, if cnt != 0: cnt <= cnt - 1.
  - md_busy = (cnt != 0).
- Because E is flushed on stall, a start can never enter E while a D-stage MD instruction is held behind a busy unit.

## Timing
- Reset values: md_cnt = 0, md_busy = 0, stall_cnt = 0. While reset is high: stall = 0, PC_WrEn = 1, D_WrEn = 1, E_flush = 0.
- Reset asserted mid-count clears the countdown at the next edge.
- stall, PC_WrEn, D_WrEn and E_flush are combinational from the inputs and md_busy, with zero latency in the same cycle.
- Mult start seen in E at cycle T: md_busy = 1 for cycles T+1..T+5 and 0 at T+6. A D-stage MD instruction stalls in cycles T..T+5 and advances at T+6.
- Div start: md_busy = 1 for cycles T+1..T+10.
- When a data hazard and the MD hazard occur together, one stall is issued. No double counting occurs.
- Register 0 never creates a hazard, regardless of the A3 match.

## Configuration
- STALL_CNT_EN defined: stall_cnt is a 32-bit counter that increments on each edge where stall = 1 and reset = 0. It wraps from 0xFFFFFFFF to 0, and reset clears it.
- STALL_CNT_EN undefined: the counter and the stall_cnt port are absent. All other behaviour is identical.

## Structure
- Shared package: Tuse/Tnew encodings (TUSE_NONE = 3), MULT_CYCLES and DIV_CYCLES defaults, and the 5-bit register index width.
- One sub-module, md_busy_timer: it owns md_cnt, takes E_md_start and E_md_is_div, and outputs md_busy.
- Hazard compare logic stays in hazard_ctrl.

## Test plan
- lw $8 in E (E_A3 = 8, E_Tnew = 2), D uses rs = 8 with Tuse = 1 → stall = 1, PC_WrEn = 0, E_flush = 1. With E_Tnew = 1 instead → stall = 0.
- D_rs = 0, E_A3 = 0, E_Tnew = 2, Tuse = 0 → stall = 0.
- Mult start at T, mflo in D from T → stall high T..T+5, low at T+6. md_busy drops exactly at T+6.
- Div start, then reset asserted at T+3 → md_busy = 0 at T+4, and stall = 0 while reset is high.
- Start while busy (forced), div then mult at T+2 → count reloads to 5, md_busy low at T+8.
- With STALL_CNT_EN: 7 stall cycles → stall_cnt = 7. With preload near wrap, 0xFFFFFFFF plus 1 stall → 0.
